eval_rr_arbiter: RTL and testbench
==================================

Name: eval_rr_arbiter

Overview:
Round-robin arbiter that shares one 4-input combinational evaluation unit (select A, data B/C/D, result H) among N_REQ requesters. It latches the winning requester's 4-bit combination and drives it onto the shared unit's inputs. It holds those inputs for a settle window, registers H and returns it to the winner with a one-cycle done pulse. It sits between the requester blocks and the single evaluation unit instance.

Parameters:
N_REQ, 4, number of requesters (>=2)
SETTLE_CYCLES, 1, cycles unit inputs are held stable before H is sampled (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req  in  N_REQ  level request, one bit per requester
req_data  in  4*N_REQ  per-requester combination; slice i = {A,B,C,D} at [4i+3:4i], A is MSB
gnt  out  N_REQ  one-hot, high while requester's data drives the unit
done  out  N_REQ  one-hot, one-cycle pulse when result is valid for that requester
result  out  1  registered H of the last completed transaction
busy  out  1  high in any state other than IDLE
unit_a, unit_b, unit_c, unit_d  out  1 each  registered inputs to the shared unit
unit_h  in  1  combinational output of the shared unit

Behaviour:
- Reset: when rst_n=0 at a rising edge, the next state is IDLE. gnt=0, done=0, result=0, busy=0, unit_*=0, settle counter=0. The last-grant pointer is set to N_REQ-1, so requester 0 has first priority. Reset overrides everything, including mid-transaction; the aborted transaction never produces done.
- FSM states: IDLE, DRIVE, DONE.
- IDLE: if any req bit is high at the edge, pick winner w = first set bit searching from (last+1) mod N_REQ upward with wrap. On that edge: unit_{a,b,c,d} <= req_data slice w, gnt[w] <= 1, last <= w, counter <= 0, state <= DRIVE. If no req, stay in IDLE with all outputs held.
- DRIVE: gnt[w] and unit_* held constant. Counter increments each cycle. When counter = SETTLE_CYCLES-1, the edge does: result <= unit_h, gnt <= 0, done[w] <= 1, state <= DONE.
- DONE: done[w] high for exactly this cycle. unit_* keep their values. Next edge: done <= 0, state <= IDLE.
- Timing: gnt is high for exactly SETTLE_CYCLES cycles. done asserts SETTLE_CYCLES cycles after gnt rises. One transaction takes SETTLE_CYCLES+2 cycles including the IDLE arbitration cycle.
- req and req_data are sampled only in IDLE. Deasserting req or changing req_data during DRIVE/DONE has no effect; the transaction completes with the latched data.
- req is level-sensitive. A requester still high in the IDLE cycle after its done is re-arbitrated as a new request, subject to round-robin order.
- result holds its value until the next DRIVE->DONE edge.
- Invariants: gnt and done are each one-hot or zero, and never both high for the same cycle.

Decomposition:
- Package eval_arb_pkg: state enum typedef (IDLE, DRIVE, DONE), the default N_REQ and SETTLE_CYCLES constants, and field index constants for A/B/C/D within a 4-bit slice.
- One sub-module, rr_pick: purely combinational. Inputs are req and the last pointer; outputs are the winner index and a valid flag. It is reusable and tested standalone.
- The FSM, counter and output registers stay in eval_rr_arbiter.
- The bench instantiates the real evaluation unit on unit_* and unit_h.

Test Plan:
All cases use N_REQ=4, SETTLE_CYCLES=1 and the real evaluation unit.
1. Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, done=0, result=0, busy=0, unit_*=0 throughout. After release, the first grant goes to requester 0.
2. Single request: req=4'b0010 with slice1=4'b0001 -> gnt[1]=1 for 1 cycle starting 1 cycle after the edge; unit_{a,b,c,d}=0,0,0,1; done[1] pulses the next cycle; result=0.
3. All four requesters at once with slices 0..3 = 0000, 0010, 1010, 1110, req held until own done -> grant order 0,1,2,3 every 3 cycles; results 1,1,1,0.
4. Fairness: req[0] and req[2] held continuously -> grants alternate 0,2,0,2 and never starve either.
5. Reset mid-DRIVE: assert rst_n=0 during gnt[3] -> next cycle all outputs 0, no done[3]. After release with req[0] high, requester 0 is granted first.
6. req drop and data change during DRIVE: requester 1 with slice 0010 drops req and changes slice to 0001 during gnt -> done[1] still pulses, result=1 from the latched 0010, and no second grant is issued.

Source files
------------

// File: rtl/eval_arb_pkg.sv
// ---------------------------------------------------------------------------
// eval_arb_pkg
// Shared types and constants for the round-robin evaluation-unit arbiter.
//   arb_state_t       : arbiter FSM state (IDLE, DRIVE, DONE)
//   DEF_N_REQ         : default number of requesters
//   DEF_SETTLE_CYCLES : default number of cycles unit inputs settle
//   FLD_A..FLD_D      : bit positions of A/B/C/D inside a 4-bit combination
// ---------------------------------------------------------------------------
package eval_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ         = 4;
    localparam int DEF_SETTLE_CYCLES = 1;

    // A is the select input and sits in the MSB of each slice.
    localparam int FLD_A = 3;
    localparam int FLD_B = 2;
    localparam int FLD_C = 1;
    localparam int FLD_D = 0;

endpackage

// File: rtl/eval_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin winner selection.
//   i_req    : request vector, one bit per requester
//   i_last   : index of the most recently granted requester
//   o_winner : first requester with its bit set, searching from
//              (i_last+1) mod N_REQ upward with wrap-around
//   o_valid  : high when any request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_valid
);

    // Walk the offsets from farthest to nearest so the nearest set bit
    // after i_last is the final assignment and therefore wins. Offset
    // N_REQ wraps back to i_last itself, which has the lowest priority.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % N_REQ]) begin
                o_winner = IDX_W'((int'(i_last) + k) % N_REQ);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eval_rr_arbiter.sv
// ---------------------------------------------------------------------------
// eval_rr_arbiter
// Shares a single combinational evaluation unit (select A, data B/C/D,
// result H) between N_REQ requesters using round-robin arbitration.
//
// Ports:
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   req               : level request per requester
//   req_data          : per-requester {A,B,C,D} slice at [4i+3:4i]
//   gnt               : one-hot, high while the winner's data drives the unit
//   done              : one-hot, single-cycle pulse when result is valid
//   result            : registered H of the last completed transaction
//   busy              : high whenever the FSM is not IDLE
//   unit_a..unit_d    : registered inputs to the shared unit
//   unit_h            : combinational output of the shared unit
//   o_dbg_state       : current FSM state, for observation only
//
// Handshake: a requester raises req and holds it level. req/req_data are
// only sampled in IDLE; the winner sees gnt for SETTLE_CYCLES cycles and
// then a one-cycle done, during which result carries its H. Anything the
// requester does to req/req_data after the grant edge is ignored. A req
// still high after done is treated as a fresh request in round-robin order.
// ---------------------------------------------------------------------------
module eval_rr_arbiter
    import eval_arb_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 result,
    output logic                 busy,
    output logic                 unit_a,
    output logic                 unit_b,
    output logic                 unit_c,
    output logic                 unit_d,
    input  logic                 unit_h,
    output logic [1:0]           o_dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    // Reset pointer to the highest index so requester 0 is searched first.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [IDX_W-1:0]  r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_done;
    logic              r_result;
    logic [3:0]        r_unit;

    logic [IDX_W-1:0]  w_winner;
    logic              w_valid;
    logic [3:0]        w_slice;
    logic [N_REQ-1:0]  w_onehot;
    logic              w_settled;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_slice   = req_data[4*int'(w_winner) +: 4];
    assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_settled = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_valid)   w_next_state = ST_DRIVE;
            ST_DRIVE: if (w_settled) w_next_state = ST_DONE;
            ST_DONE:                 w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last   <= LAST_RST;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= 1'b0;
            r_unit   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_unit <= w_slice;
                        r_gnt  <= w_onehot;
                        r_last <= w_winner;
                        r_cnt  <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (w_settled) begin
                        r_result <= unit_h;
                        r_gnt    <= '0;
                        // gnt already holds the winner's one-hot bit.
                        r_done   <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= '0;
                end
                default: begin
                    r_gnt  <= '0;
                    r_done <= '0;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign result      = r_result;
    assign busy        = (r_state != ST_IDLE);
    assign unit_a      = r_unit[FLD_A];
    assign unit_b      = r_unit[FLD_B];
    assign unit_c      = r_unit[FLD_C];
    assign unit_d      = r_unit[FLD_D];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_eval_rr_arbiter.sv
module tb_eval_rr_arbiter;

  localparam int N = 4;
  localparam int S = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           result;
  logic           busy;
  logic           unit_a, unit_b, unit_c, unit_d;
  logic           unit_h;
  logic [1:0]     dbg_state;

  // Shared evaluation unit: A selects between B xor C and not D.
  assign unit_h = unit_a ? (unit_b ^ unit_c) : ~unit_d;

  eval_rr_arbiter #(.N_REQ(N), .SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .busy        (busy),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_c      (unit_c),
    .unit_d      (unit_d),
    .unit_h      (unit_h),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t counts cycles into the current transaction: 0 = idle,
  // 1..S = granted, S+1 = done cycle.
  int         m_t = 0;
  int         m_win = 0;
  int         m_last = N - 1;
  logic [3:0] m_unit = '0;
  logic       m_result = 1'b0;

  function automatic logic eval_h(input logic [3:0] v);
    if (v[3]) return v[2] ^ v[1];
    return ~v[0];
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_t = 0; m_last = N - 1; m_unit = '0; m_result = 1'b0;
    end else if (m_t == 0) begin
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_last + k) % N]) begin
            m_win = (m_last + k) % N;
            break;
          end
        end
        m_unit = req_data[4*m_win +: 4];
        m_last = m_win;
        m_t = 1;
      end
    end else if (m_t < S) begin
      m_t++;
    end else if (m_t == S) begin
      m_result = eval_h(m_unit);
      m_t = S + 1;
    end else begin
      m_t = 0;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    eg = '0;
    ed = '0;
    if (m_t >= 1 && m_t <= S) eg[m_win] = 1'b1;
    if (m_t == S + 1) ed[m_win] = 1'b1;
    cmp("m_gnt", 32'(gnt), 32'(eg));
    cmp("m_done", 32'(done), 32'(ed));
    cmp("m_busy", 32'(busy), 32'(m_t != 0));
    cmp("m_result", 32'(result), 32'(m_result));
    cmp("m_unit", 32'({unit_a, unit_b, unit_c, unit_d}), 32'(m_unit));
    cmp("inv_gnt_done", 32'((gnt & done) == '0 && $onehot0(gnt) && $onehot0(done)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        result;
    logic        busy;
    logic [3:0]  unit;
  } vec_t;

  vec_t vecs[$];
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  initial begin
    // rst req   data      gnt   done  res busy unit
    vecs.push_back('{1'b0, 4'hF, 16'hEA20, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 16'hEA20, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 16'hEA20, 4'h1, 4'h0, 1'b0, 1'b1, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 16'hEA20, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0});
    vecs.push_back('{1'b1, 4'hE, 16'hEA20, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hE, 16'hEA20, 4'h2, 4'h0, 1'b1, 1'b1, 4'h2});
    vecs.push_back('{1'b1, 4'hE, 16'hEA20, 4'h0, 4'h2, 1'b1, 1'b1, 4'h2});
    vecs.push_back('{1'b1, 4'hC, 16'hEA20, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2});
    vecs.push_back('{1'b1, 4'hC, 16'hEA20, 4'h4, 4'h0, 1'b1, 1'b1, 4'hA});
    vecs.push_back('{1'b1, 4'hC, 16'hEA20, 4'h0, 4'h4, 1'b1, 1'b1, 4'hA});
    vecs.push_back('{1'b1, 4'h8, 16'hEA20, 4'h0, 4'h0, 1'b1, 1'b0, 4'hA});
    vecs.push_back('{1'b1, 4'h8, 16'hEA20, 4'h8, 4'h0, 1'b1, 1'b1, 4'hE});
    vecs.push_back('{1'b1, 4'h8, 16'hEA20, 4'h0, 4'h8, 1'b0, 1'b1, 4'hE});
    vecs.push_back('{1'b1, 4'h0, 16'hEA20, 4'h0, 4'h0, 1'b0, 1'b0, 4'hE});
    // single request from requester 1 with combination 0001
    vecs.push_back('{1'b1, 4'h2, 16'h0010, 4'h2, 4'h0, 1'b0, 1'b1, 4'h1});
    vecs.push_back('{1'b1, 4'h0, 16'h0010, 4'h0, 4'h2, 1'b0, 1'b1, 4'h1});
    vecs.push_back('{1'b1, 4'h0, 16'h0010, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1});
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    bit saw_done3;

    #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      req = vecs[i].req;
      req_data = vecs[i].data;
      tick();
      cmp($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      cmp($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      cmp($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].result));
      cmp($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      cmp($sformatf("v%0d_unit", i), 32'({unit_a, unit_b, unit_c, unit_d}), 32'(vecs[i].unit));
    end

    // Fairness: 0 and 2 held; last grant was 1, so 2 goes first.
    exp_q = '{2'd2, 2'd0, 2'd2, 2'd0};
    req = 4'b0101;
    req_data = 16'h0000;
    for (int c = 0; c < 30 && got_q.size() < 4; c++) begin
      tick();
      for (int b = 0; b < N; b++) if (gnt[b]) got_q.push_back(2'(b));
    end
    cmp("fair_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      cmp($sformatf("fair_order%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    req = '0;
    for (int c = 0; c < 10 && busy; c++) tick();
    cmp("fair_drain", 32'(busy), 32'd0);

    // Reset in the middle of requester 3's grant.
    req = 4'b1000;
    req_data = 16'hE000;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt[3]) begin ok = 1; break; end
    end
    cmp("rst_mid_gnt3_seen", 32'(ok), 32'd1);
    rst_n = 1'b0;
    req = 4'b0001;
    tick();
    cmp("rst_mid_gnt", 32'(gnt), 32'd0);
    cmp("rst_mid_done", 32'(done), 32'd0);
    cmp("rst_mid_busy", 32'(busy), 32'd0);
    cmp("rst_mid_unit", 32'({unit_a, unit_b, unit_c, unit_d}), 32'd0);
    rst_n = 1'b1;
    saw_done3 = 0;
    tick();
    cmp("rst_mid_regrant0", 32'(gnt), 32'd1);
    req = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done[3]) saw_done3 = 1;
    end
    cmp("rst_mid_no_done3", 32'(saw_done3), 32'd0);

    // Requester 1 drops req and changes data while granted.
    req = 4'b0010;
    req_data = 16'h0020;
    tick();
    cmp("drop_gnt", 32'(gnt), 32'd2);
    req = '0;
    req_data = 16'h0010;
    tick();
    cmp("drop_done", 32'(done), 32'd2);
    cmp("drop_result", 32'(result), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      cmp($sformatf("drop_no_regrant%0d", c), 32'(gnt), 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      req = 4'($urandom_range(0, 15));
      req_data = 16'($urandom);
      tick();
    end
    rst_n = 1'b1;
    req = '0;
    for (int c = 0; c < 5; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
